mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 10, meaning RAM/ROM word-address width (depth 2^ADDRWIDTH).
REQ-002 SHALL have parameter DATAWIDTH, default 32, meaning memory word width.
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  load-stream word valid.
REQ-006 SHALL have port in_ready  output  1  loader accepts word this cycle.
REQ-007 SHALL have port in_data  input  DATAWIDTH  load-stream word.
REQ-008 SHALL have port reload  input  1  single-cycle request to restart loading.
REQ-009 SHALL have port mem_write  output  1  write strobe, one cycle per data word.
REQ-010 SHALL have port mem_target  output  1  0 = data RAM, 1 = instruction ROM.
REQ-011 SHALL have port mem_address  output  ADDRWIDTH  word address.
REQ-012 SHALL have port mem_wdata  output  DATAWIDTH  write data.
REQ-013 SHALL have port core_nreset  output  1  core reset, low holds core.
REQ-014 SHALL have port done  output  1  image loaded, checksum good.
REQ-015 SHALL have port error  output  1  checksum or range failure.

Function
REQ-016 SHALL implement states HEADER, COUNT, DATA, CHECK, DONE, ERROR; transfer occurs only when in_valid and in_ready both high at a rising edge.
REQ-017 SHALL drive in_ready high in HEADER, COUNT, DATA, CHECK; low in DONE, ERROR.
REQ-018 HEADER: accepted word bit 31 latched as target, bits [ADDRWIDTH-1:0] as start address; -> COUNT.
REQ-019 COUNT: accepted word bits [15:0] latched as N; checksum accumulator cleared; if start+N > 2^ADDRWIDTH -> ERROR; else if N = 0 -> CHECK; else -> DATA.
REQ-020 DATA: each accepted word produces mem_write=1 exactly one cycle after the handshake edge, with mem_address = start + index (index 0..N-1), mem_wdata = word, mem_target = latched target.
REQ-021 DATA: accumulator += word, modulo 2^DATAWIDTH; after the N-th word -> CHECK.
REQ-022 CHECK: accepted word compared to accumulator; equal -> DONE, unequal -> ERROR.
REQ-023 SHALL hold mem_write low in all cycles not given by REQ-020; mem_address/mem_wdata hold last values when idle.
REQ-024 in_valid low stalls any state with no state change; back-to-back words accepted every cycle (no bubbles).
REQ-025 DONE: done=1, core_nreset=1 (registered, asserted the cycle after entering DONE); all other states core_nreset=0.
REQ-026 ERROR: error=1, done=0, core_nreset=0.
REQ-027 reload=1 in any state -> HEADER next cycle, done/error cleared, core_nreset=0; a word handshaken in the same cycle as reload SHALL be discarded (no write, no accumulate).
REQ-028 SHALL never produce address wrap: range check of REQ-019 guarantees last address <= 2^ADDRWIDTH-1.

Reset
REQ-029 reset high SHALL immediately force state HEADER, mem_write=0, mem_target=0, mem_address=0, mem_wdata=0, core_nreset=0, done=0, error=0, accumulator=0, N=0.
REQ-030 in_ready SHALL be 0 while reset is high and 1 from the first edge after reset release.
REQ-031 reset asserted mid-DATA SHALL abort the load; no further mem_write until a full new image is sent.

Verification
REQ-032 Header 0x80000004, count 3, data 0x13,0x00100093,0x00208113, checksum 0x003081B9 -> ROM writes at 4,5,6 with those data, done=1, core_nreset=1.
REQ-033 Header 0x00000000, count 2, data 7,8, checksum 0x10 -> two RAM writes at 0,1, then error=1, core_nreset stays 0.
REQ-034 Header 0x000003FE, count 3 -> error=1 immediately after count word, zero writes.
REQ-035 Header 0x00000010, count 0, checksum 0 -> done=1, no writes.
REQ-036 Random in_valid gaps (50%) during 16-word load -> writes identical to gapless run, one write per accepted word, latency 1 cycle.
REQ-037 reset pulse after 2nd data word, then reload-free full image; and reload pulse in DONE concurrent with in_valid -> HEADER, word discarded, core_nreset drops to 0.

Source files
------------

// File: rtl/mem_loader_if.sv
// Load-stream and memory-write signal bundle for the image loader.
// master: image source / memory side (drives in_*, observes mem_*).
// slave: the loader itself.
interface mem_loader_if #(
  parameter int unsigned ADDRWIDTH = 10,
  parameter int unsigned DATAWIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] in_data;
  logic                 mem_write;
  logic                 mem_target;
  logic [ADDRWIDTH-1:0] mem_address;
  logic [DATAWIDTH-1:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_write, mem_target, mem_address, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_write, mem_target, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_loader.sv
// Streams a header/count/data/checksum image into RAM or ROM, verifies the
// checksum and releases the core from reset only on a good image.
module mem_loader #(
  parameter int unsigned ADDRWIDTH = 10,
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  mem_loader_if.slave  bus,
  input  logic         reload,
  output logic         core_nreset,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {
    StHeader,
    StCount,
    StData,
    StCheck,
    StDone,
    StError
  } state_e;

  // Wide enough to hold start + N without overflow.
  localparam int unsigned SumW = ((ADDRWIDTH > 16) ? ADDRWIDTH : 16) + 1;

  state_e               state_q, state_d;
  logic                 ready_q;
  logic                 target_q;
  logic [ADDRWIDTH-1:0] start_q;
  logic [15:0]          n_q;
  logic [15:0]          idx_q;
  logic [DATAWIDTH-1:0] acc_q;
  logic                 mem_write_q;
  logic                 mem_target_q;
  logic [ADDRWIDTH-1:0] mem_address_q;
  logic [DATAWIDTH-1:0] mem_wdata_q;
  logic                 core_nreset_q;

  logic                 fire;
  logic                 accept;
  logic                 range_bad;
  logic                 last_word;
  logic [SumW-1:0]      end_addr;
  logic [SumW-1:0]      addr_limit;

  // ready_q keeps in_ready low until the first edge after reset release.
  assign bus.in_ready = ready_q &&
                        ((state_q == StHeader) || (state_q == StCount) ||
                         (state_q == StData)   || (state_q == StCheck));
  assign fire   = bus.in_valid && bus.in_ready;
  // A word handshaken alongside reload is dropped.
  assign accept = fire && !reload;

  assign end_addr   = SumW'(start_q) + SumW'(bus.in_data[15:0]);
  assign addr_limit = SumW'(1) << ADDRWIDTH;
  assign range_bad  = end_addr > addr_limit;
  assign last_word  = ({1'b0, idx_q} + 17'd1) == {1'b0, n_q};

  assign bus.mem_write   = mem_write_q;
  assign bus.mem_target  = mem_target_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign core_nreset     = core_nreset_q;
  assign done            = (state_q == StDone);
  assign error           = (state_q == StError);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StHeader;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; reload overrides everything, stalls hold state.
  always_comb begin
    state_d = state_q;
    if (reload) begin
      state_d = StHeader;
    end else if (fire) begin
      unique case (state_q)
        StHeader: state_d = StCount;
        StCount: begin
          if (range_bad) begin
            state_d = StError;
          end else if (bus.in_data[15:0] == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StData;
          end
        end
        StData:  if (last_word) state_d = StCheck;
        StCheck: state_d = (bus.in_data == acc_q) ? StDone : StError;
        default: state_d = state_q;
      endcase
    end
  end

  // Image fields, checksum accumulation and the registered write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q       <= 1'b0;
      target_q      <= 1'b0;
      start_q       <= '0;
      n_q           <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      mem_write_q   <= 1'b0;
      mem_target_q  <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      core_nreset_q <= 1'b0;
    end else begin
      ready_q       <= 1'b1;
      mem_write_q   <= 1'b0;
      // Core leaves reset one cycle after DONE is entered.
      core_nreset_q <= (state_q == StDone) && !reload;
      if (accept) begin
        case (state_q)
          StHeader: begin
            target_q <= bus.in_data[31];
            start_q  <= bus.in_data[ADDRWIDTH-1:0];
          end
          StCount: begin
            n_q   <= bus.in_data[15:0];
            idx_q <= '0;
            acc_q <= '0;
          end
          StData: begin
            mem_write_q   <= 1'b1;
            mem_target_q  <= target_q;
            mem_address_q <= start_q + ADDRWIDTH'(idx_q);
            mem_wdata_q   <= bus.in_data;
            acc_q         <= acc_q + bus.in_data;
            idx_q         <= idx_q + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Randomised scoreboard bench for mem_loader: the driver pushes expected
// writes as words are accepted, a negedge monitor pops and compares them.
module tb_mem_loader;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int Depth = 1 << AW;

  logic clock = 1'b0;
  logic reset;
  logic reload;
  logic core_nreset;
  logic done;
  logic error;

  always #5 clock = ~clock;

  mem_loader_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bus ();

  mem_loader #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .reload      (reload),
    .core_nreset (core_nreset),
    .done        (done),
    .error       (error)
  );

  typedef struct {
    logic          tgt;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] dq[$];
  int          cyc_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          gaps = 1'b0;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clock) begin
    if (bus.mem_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("write without accepted word", 64'(exp_q.size()), 64'd1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write address", 64'(bus.mem_address), 64'(e.addr));
        check("write data", 64'(bus.mem_wdata), 64'(e.data));
        check("write target", 64'(bus.mem_target), 64'(e.tgt));
        check("write latency", 64'(cyc_cnt), 64'(e.cyc));
      end
    end
  end

  // Present one word, optionally after random idle cycles; ok=0 on timeout.
  task automatic send_word(input logic [31:0] w, output bit ok);
    int waitc = 0;
    int g = 0;
    if (gaps) begin
      while ($urandom_range(1) == 1 && g < 8) begin
        bus.in_valid = 1'b0;
        @(posedge clock); #1;
        g++;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && waitc < 50) begin
      @(posedge clock); #1;
      waitc++;
    end
    ok = bus.in_ready;
    if (!ok) begin
      check("in_ready wait", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  // Send a complete image (data taken from dq) and check the outcome.
  task automatic run_image(input logic [31:0] header, input logic [31:0] count,
                           input logic [31:0] checksum);
    bit          ok;
    logic        tgt;
    int          start;
    int          n;
    logic [31:0] sum = 32'd0;
    tgt   = header[31];
    start = int'(header[AW-1:0]);
    n     = int'(count[15:0]);
    send_word(header, ok);
    if (!ok) return;
    send_word(count, ok);
    if (!ok) return;
    if (start + n > Depth) begin
      check("range error flag", 64'(error), 64'd1);
      check("range done flag", 64'(done), 64'd0);
      check("range in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clock); #1;
      check("range core_nreset", 64'(core_nreset), 64'd0);
      check("range no writes", 64'(exp_q.size()), 64'd0);
      return;
    end
    foreach (dq[i]) begin
      wr_t e;
      send_word(dq[i], ok);
      if (!ok) return;
      e.tgt  = tgt;
      e.addr = AW'(start + i);
      e.data = dq[i];
      e.cyc  = cyc_cnt;
      exp_q.push_back(e);
      sum += dq[i];
    end
    send_word(checksum, ok);
    if (!ok) return;
    if (sum == checksum) begin
      check("done flag", 64'(done), 64'd1);
      check("done error flag", 64'(error), 64'd0);
      check("core_nreset delayed", 64'(core_nreset), 64'd0);
      @(posedge clock); #1;
      check("core_nreset released", 64'(core_nreset), 64'd1);
    end else begin
      check("checksum error flag", 64'(error), 64'd1);
      check("checksum done flag", 64'(done), 64'd0);
      @(posedge clock); #1;
      check("error core_nreset", 64'(core_nreset), 64'd0);
    end
    check("final in_ready", 64'(bus.in_ready), 64'd0);
    check("writes drained", 64'(exp_q.size()), 64'd0);
  endtask

  // One-cycle reload pulse, optionally with a word presented alongside.
  task automatic do_reload(input logic v, input logic [31:0] w);
    bus.in_valid = v;
    bus.in_data  = w;
    reload       = 1'b1;
    @(posedge clock); #1;
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    check("reload in_ready", 64'(bus.in_ready), 64'd1);
    check("reload done", 64'(done), 64'd0);
    check("reload error", 64'(error), 64'd0);
    check("reload core_nreset", 64'(core_nreset), 64'd0);
  endtask

  task automatic random_image(input int n, input bit good);
    logic        tgt;
    int          start;
    logic [31:0] sum = 32'd0;
    tgt   = 1'($urandom_range(1));
    start = (n > 0) ? $urandom_range(Depth - n) : $urandom_range(Depth - 1);
    dq.delete();
    for (int i = 0; i < n; i++) begin
      dq.push_back($urandom);
      sum += dq[i];
    end
    run_image({tgt, 21'($urandom), AW'(start)}, {16'($urandom), 16'(n)},
              good ? sum : sum + 32'd1 + 32'($urandom_range(1000)));
  endtask

  initial begin
    bit ok;
    reset        = 1'b1;
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst in_ready", 64'(bus.in_ready), 64'd0);
    check("rst mem_write", 64'(bus.mem_write), 64'd0);
    check("rst mem_address", 64'(bus.mem_address), 64'd0);
    check("rst mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst mem_target", 64'(bus.mem_target), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst error", 64'(error), 64'd0);
    check("rst core_nreset", 64'(core_nreset), 64'd0);
    reset = 1'b0;
    check("in_ready before first edge", 64'(bus.in_ready), 64'd0);
    @(posedge clock); #1;
    check("in_ready after first edge", 64'(bus.in_ready), 64'd1);

    // ROM image, good checksum.
    dq = '{32'h13, 32'h0010_0093, 32'h0020_8113};
    run_image(32'h8000_0004, 32'd3, 32'h0030_81B9);
    // Reload in DONE with a word presented: nothing written, core held.
    do_reload(1'b1, 32'hDEAD_BEEF);

    // RAM image, bad checksum.
    dq = '{32'd7, 32'd8};
    run_image(32'h0000_0000, 32'd2, 32'h10);
    do_reload(1'b0, 32'd0);

    // Out of range by one word.
    dq.delete();
    run_image(32'h0000_03FE, 32'd3, 32'd0);
    do_reload(1'b0, 32'd0);

    // Exactly fills the top of memory.
    dq = '{32'hA, 32'hB, 32'hC};
    run_image(32'h0000_03FD, 32'd3, 32'h21);
    do_reload(1'b0, 32'd0);

    // Empty image.
    dq.delete();
    run_image(32'h0000_0010, 32'd0, 32'd0);
    do_reload(1'b0, 32'd0);

    // 16 words with gaps, then the same image without.
    gaps = 1'b1;
    random_image(16, 1'b1);
    do_reload(1'b0, 32'd0);
    gaps = 1'b0;
    random_image(16, 1'b1);
    do_reload(1'b0, 32'd0);

    // Reload mid-DATA with a concurrent handshake: that word is dropped.
    send_word(32'h0000_0020, ok);
    send_word(32'd4, ok);
    send_word(32'h1234_5678, ok);
    begin
      wr_t e;
      e.tgt = 1'b0; e.addr = AW'(32); e.data = 32'h1234_5678; e.cyc = cyc_cnt;
      exp_q.push_back(e);
    end
    do_reload(1'b1, 32'h5555_AAAA);
    repeat (2) @(posedge clock);
    #1;
    check("reload drop no write", 64'(exp_q.size()), 64'd0);
    dq = '{32'h1, 32'h2};
    run_image(32'h8000_0100, 32'd2, 32'h3);

    // Reset after the second data word, then a fresh image.
    do_reload(1'b0, 32'd0);
    send_word(32'h0000_0040, ok);
    send_word(32'd5, ok);
    for (int i = 0; i < 2; i++) begin
      wr_t e;
      send_word(32'h100 + 32'(i), ok);
      e.tgt = 1'b0; e.addr = AW'(64 + i); e.data = 32'h100 + 32'(i); e.cyc = cyc_cnt;
      exp_q.push_back(e);
    end
    @(negedge clock); #1;
    reset = 1'b1;
    #1;
    check("mid rst in_ready", 64'(bus.in_ready), 64'd0);
    check("mid rst mem_address", 64'(bus.mem_address), 64'd0);
    check("mid rst core_nreset", 64'(core_nreset), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom;
    repeat (2) @(posedge clock);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    check("mid rst ready held", 64'(bus.in_ready), 64'd0);
    @(posedge clock); #1;
    check("mid rst ready back", 64'(bus.in_ready), 64'd1);
    check("mid rst writes", 64'(exp_q.size()), 64'd0);
    dq = '{32'hFFFF_FFFF, 32'h2, 32'h3};
    run_image(32'h0000_0040, 32'd3, 32'h4);

    // Random mix, including range failures and bad checksums.
    for (int k = 0; k < 8; k++) begin
      do_reload(1'b0, 32'd0);
      gaps = 1'($urandom_range(1));
      if (k % 4 == 3) begin
        dq.delete();
        run_image({1'b0, 21'd0, AW'($urandom_range(Depth - 1, Depth - 8))},
                  32'($urandom_range(200, 9)), 32'd0);
      end else begin
        random_image($urandom_range(20, 1), $urandom_range(3) != 0);
      end
    end

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
